// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Two-port writeback arbiter. Per-port FIFOs, round-robin drain
//            into a registered register-bank write port, pending-write mask.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        reg_write,
    output logic [4:0]  write_register,
    output logic [31:0] write_data,
    output logic [31:0] pending_mask
);

    localparam int             PW          = $clog2(DEPTH);
    localparam logic [PW:0]    c_DEPTH_CNT = (PW+1)'(DEPTH);
    localparam logic           c_GRANT_A   = 1'b0;
    localparam logic           c_GRANT_B   = 1'b1;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]  w_in_valid;
    logic [1:0]  w_ready;
    logic [1:0]  w_push;
    logic [1:0]  w_pop;
    logic [1:0]  w_nonempty;
    logic [4:0]  w_in_addr   [2];
    logic [31:0] w_in_data   [2];
    logic [4:0]  w_head_addr [2];
    logic [31:0] w_head_data [2];
    logic [31:0] w_fifo_mask [2];

    logic        w_grant_a;
    logic        w_grant_b;
    logic        r_last_grant;
    logic        r_reg_write;
    logic [4:0]  r_write_register;
    logic [31:0] r_write_data;

    assign w_in_valid   = {b_valid, a_valid};
    assign w_in_addr[0] = a_addr;
    assign w_in_addr[1] = b_addr;
    assign w_in_data[0] = a_data;
    assign w_in_data[1] = b_data;

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [4:0]    r_addr [DEPTH];
        logic [31:0]   r_data [DEPTH];
        logic [PW-1:0] r_wr_ptr;
        logic [PW-1:0] r_rd_ptr;
        logic [PW:0]   r_count;

        assign w_ready[p]     = (r_count < c_DEPTH_CNT);
        // Address 0 completes the handshake but is never stored.
        assign w_push[p]      = w_in_valid[p] && w_ready[p] && (w_in_addr[p] != 5'd0);
        assign w_nonempty[p]  = (r_count != '0);
        assign w_head_addr[p] = r_addr[r_rd_ptr];
        assign w_head_data[p] = r_data[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[p]) begin
                    r_addr[r_wr_ptr] <= w_in_addr[p];
                    r_data[r_wr_ptr] <= w_in_data[p];
                    r_wr_ptr         <= r_wr_ptr + 1'b1;
                end
                if (w_pop[p]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push[p], w_pop[p]})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        // An entry is live when its distance from the read pointer is below count.
        always_comb begin
            logic [PW-1:0] idx;
            logic [PW-1:0] off;
            idx            = '0;
            off            = '0;
            w_fifo_mask[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx = PW'(i);
                off = idx - r_rd_ptr;
                if ({1'b0, off} < r_count) begin
                    w_fifo_mask[p] = w_fifo_mask[p] | (32'd1 << r_addr[idx]);
                end
            end
        end
    end

    assign w_grant_a = w_nonempty[0] && (!w_nonempty[1] || (r_last_grant == c_GRANT_B));
    assign w_grant_b = w_nonempty[1] && !w_grant_a;
    assign w_pop     = {w_grant_b, w_grant_a};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_last_grant     <= c_GRANT_B;
        end else begin
            r_reg_write <= w_grant_a || w_grant_b;
            if (w_grant_a) begin
                r_write_register <= w_head_addr[0];
                r_write_data     <= w_head_data[0];
                r_last_grant     <= c_GRANT_A;
            end else if (w_grant_b) begin
                r_write_register <= w_head_addr[1];
                r_write_data     <= w_head_data[1];
                r_last_grant     <= c_GRANT_B;
            end
        end
    end

    assign a_ready        = w_ready[0];
    assign b_ready        = w_ready[1];
    assign reg_write      = r_reg_write;
    assign write_register = r_write_register;
    assign write_data     = r_write_data;
    assign pending_mask   = w_fifo_mask[0] | w_fifo_mask[1]
                          | (r_reg_write ? (32'd1 << r_write_register) : 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed and random stimulus checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [31:0] pending_mask;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .pending_mask   (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    // Reference model: one queue per port, last winner, and the presented write.
    ent_t        qa[$];
    ent_t        qb[$];
    logic        m_last_b;
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (qa[i]) m |= 32'd1 << qa[i].addr;
        foreach (qb[i]) m |= 32'd1 << qb[i].addr;
        if (m_rw) m |= 32'd1 << m_wr;
        return m;
    endfunction

    // Called at a falling edge: drives inputs, checks ready, steps one rising edge,
    // advances the model and checks the outputs at the next falling edge.
    task automatic cycle(input logic va, input logic [4:0] aa, input logic [31:0] da,
                         input logic vb, input logic [4:0] ab, input logic [31:0] db,
                         input logic r, input string tag);
        logic acc_a, acc_b, ne_a, ne_b;
        ent_t e;
        a_valid = va; a_addr = aa; a_data = da;
        b_valid = vb; b_addr = ab; b_data = db;
        rst = r;
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(qa.size() < DEPTH));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(qb.size() < DEPTH));
        @(posedge clk);
        if (r) begin
            qa.delete(); qb.delete();
            m_last_b = 1'b1; m_rw = 1'b0; m_wr = '0; m_wd = '0;
        end else begin
            acc_a = va && (qa.size() < DEPTH);
            acc_b = vb && (qb.size() < DEPTH);
            ne_a  = qa.size() != 0;
            ne_b  = qb.size() != 0;
            m_rw  = 1'b0;
            if (ne_a && (!ne_b || m_last_b)) begin
                e = qa.pop_front(); m_rw = 1'b1; m_wr = e.addr; m_wd = e.data; m_last_b = 1'b0;
            end else if (ne_b) begin
                e = qb.pop_front(); m_rw = 1'b1; m_wr = e.addr; m_wd = e.data; m_last_b = 1'b1;
            end
            if (acc_a && aa != 5'd0) qa.push_back('{addr: aa, data: da});
            if (acc_b && ab != 5'd0) qb.push_back('{addr: ab, data: db});
        end
        @(negedge clk);
        chk({tag, ".reg_write"},      32'(reg_write),      32'(m_rw));
        chk({tag, ".write_register"}, 32'(write_register), 32'(m_wr));
        chk({tag, ".write_data"},     write_data,          m_wd);
        chk({tag, ".pending_mask"},   pending_mask,        model_mask());
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, tag);
    endtask

    initial begin
        m_last_b = 1'b1; m_rw = 1'b0; m_wr = '0; m_wd = '0;
        @(negedge clk);

        // Reset held for two cycles with requests asserted.
        cycle(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222, 1'b1, "rst0");
        cycle(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222, 1'b1, "rst1");
        chk("rst.reg_write", 32'(reg_write), 32'd0);
        chk("rst.pending",   pending_mask,   32'd0);
        idle(1, "post_rst");
        chk("post_rst.a_ready", 32'(a_ready), 32'd1);
        chk("post_rst.b_ready", 32'(b_ready), 32'd1);

        // Single write: mask 0x20 next cycle, one-cycle write pulse after that.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, "single_push");
        chk("single.mask_n1", pending_mask, 32'h0000_0020);
        chk("single.rw_n1",   32'(reg_write), 32'd0);
        idle(1, "single_n2");
        chk("single.rw_n2",   32'(reg_write), 32'd1);
        chk("single.wr_n2",   32'(write_register), 32'd5);
        chk("single.wd_n2",   write_data, 32'hDEAD_BEEF);
        idle(1, "single_n3");
        chk("single.rw_n3",   32'(reg_write), 32'd0);
        chk("single.mask_n3", pending_mask, 32'd0);
        chk("single.hold_wd", write_data, 32'hDEAD_BEEF);

        // Tie and fairness: both ports saturated.
        for (int i = 1; i <= 12; i++)
            cycle(1'b1, 5'(i), 32'hA000_0000 + 32'(i),
                  1'b1, 5'(i + 16), 32'hB000_0000 + 32'(i), 1'b0, "tie");
        chk("tie.a_full", 32'(a_ready), 32'd0);
        idle(6, "tie_drain");

        // Three back-to-back A requests, B busy so A's FIFO fills.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'(10 + i), 32'hC000_0000 + 32'(i),
                  1'b1, 5'(20 + i), 32'hD000_0000 + 32'(i), 1'b0, "full");
        idle(6, "full_drain");

        // Address 0 handshakes but never writes.
        cycle(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, "addr0");
        chk("addr0.mask", pending_mask, 32'd0);
        idle(2, "addr0_after");
        chk("addr0.rw", 32'(reg_write), 32'd0);

        // Reset with writes in flight.
        cycle(1'b1, 5'd3, 32'h0303_0303, 1'b1, 5'd4, 32'h0404_0404, 1'b0, "mid_q0");
        cycle(1'b1, 5'd6, 32'h0606_0606, 1'b1, 5'd8, 32'h0808_0808, 1'b0, "mid_q1");
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, "mid_rst");
        chk("mid_rst.rw",   32'(reg_write), 32'd0);
        chk("mid_rst.mask", pending_mask,   32'd0);
        idle(4, "mid_after");

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 99) == 0, "rand");
        idle(6, "rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
